window_gen_3x3: RTL and testbench
=================================

// Module: window_gen_3x3
// PURPOSE
//  Upstream stage of the median filter datapath. Converts a raster pixel stream into
//  3x3 neighbourhood windows D0..D8, one per pixel, centred on (Row_o,Col_o).
//  Two internal line buffers hold the rows. Out-of-image taps are padded at the borders.
//  The median core consumes the windows through a valid/ready handshake.
// PARAMETERS
//  IMG_W      512  image width in pixels (>=3)
//  IMG_H      512  image height in pixels (>=2)
//  DW         8    pixel width in bits
//  PAD_VALUE  0    value driven on out-of-image taps (non-replicate build only)
// PORTS
//  clk        in   1     single clock, rising edge
//  rst        in   1     asynchronous reset, active-low
//  start      in   1     one-cycle pulse; begins a frame from IDLE or DONE
//  in_valid   in   1     pixel_in is valid
//  in_ready   out  1     stage accepts pixel_in this cycle
//  pixel_in   in   DW    raster-order pixel, row 0 col 0 first
//  out_valid  out  1     window outputs valid
//  out_ready  in   1     downstream accepts the window
//  D0..D8     out  DW    each; window, raster order: D0=(r-1,c-1) .. D4=centre .. D8=(r+1,c+1)
//  Row_o      out  10    centre row of the current window
//  Col_o      out  10    centre column of the current window
//  State      out  3     FSM state
//  done       out  1     one-cycle pulse after the last window is accepted
// BEHAVIOUR
//  Reset (rst=0, async): State=IDLE, in_ready=0, out_valid=0, done=0, D*=0, Row_o=Col_o=0,
//   counters=0, line-buffer contents don't-care. A reset mid-frame abandons the frame.
//  FSM states: IDLE=0 FILL=1 RUN=2 FLUSH=3 DONE=4.
//   IDLE  -start-> FILL. DONE -start-> FILL. start is ignored in FILL/RUN/FLUSH.
//   FILL: accept pixels; no output. Go to RUN on accepting input index IMG_W+1.
//   RUN: each accepted input k emits the window centred on raster index k-(IMG_W+1).
//    Go to FLUSH after input IMG_W*IMG_H-1 is accepted.
//   FLUSH: in_ready=0. Emit the remaining IMG_W+1 windows using internal padding slots.
//    Go to DONE when the last window (IMG_H-1, IMG_W-1) is accepted.
//   DONE: done=1 for exactly one cycle, then IDLE.
//  Lag and latency:
//   Fixed lag of IMG_W+1 slots between input and output.
//   Output is registered: out_valid rises the cycle after the triggering slot.
//  Handshake:
//   Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
//   in_ready = (FILL|RUN) & !(out_valid & !out_ready).
//   While stalled, D*, Row_o and Col_o hold stable. No pixel is dropped or duplicated.
//   in_valid bubbles insert idle cycles only; the output sequence is unchanged.
//  Borders: taps with row<0, row>=IMG_H, col<0 or col>=IMG_W are out-of-image.
//   Column wrap is masked: col 0 never sees the previous row's last pixel.
//  Counters: Row_o/Col_o wrap col IMG_W-1 -> 0 with row+1.
//   Exactly IMG_W*IMG_H windows per frame.
// CONFIGURATION
//  Macro BORDER_REPLICATE_EN:
//   Undefined: every out-of-image tap = PAD_VALUE.
//   Defined: out-of-image taps take the nearest in-image pixel. Rows are clamped first,
//    then columns. Example at (0,0): D0=D1=D3=D4, D2=D5, D6=D7. PAD_VALUE is unused.
// STRUCTURE
//  Shared header median_pkg.vh holds:
//   state encodings, IMG_W/IMG_H defaults, coordinate width 10, and the D-index map.
//  Sub-module line_buffer #(DEPTH=IMG_W, DW): one-row delay.
//   One write and one read per advanced slot. Two instances (row-1, row-2).
//  The top level holds the FSM, counters, 3x3 shift registers, border mux and output register.
// TESTING  (IMG_W=4, IMG_H=3, pixel value = raster index 0..11)
//  1 Reset: rst=0 mid-frame -> State=0, out_valid=0, in_ready=0, done=0, all D*=0 immediately.
//  2 Ramp, out_ready=1, no macro:
//    First out_valid the cycle after input 5 is accepted, centre (0,0): D=0,0,0,0,0,1,0,4,5.
//    Centre (1,1): D=0,1,2,4,5,6,8,9,10.
//    12 windows total; done pulses once after window (2,3) = D 6,7,0,10,11,0,0,0,0.
//  3 BORDER_REPLICATE_EN, same ramp:
//    (0,0) -> D=0,0,1,0,0,1,4,4,5. (2,3) -> D=6,7,7,10,11,11,10,11,11.
//  4 Backpressure: out_ready=0 for 3 cycles at window (1,2).
//    D*/Row_o/Col_o are held and in_ready=0; the sequence is identical to test 2.
//  5 Input bubbles: in_valid toggles every other cycle -> window sequence identical to test 2.
//  6 Restart: start in DONE -> second frame correct.
//    start pulse during RUN -> ignored, frame unaffected.

Source files
------------

// File: rtl/window_gen_3x3_pkg.sv
// window_gen_3x3_pkg: shared types, default geometry and window tap helpers
// for the 3x3 window generator.
package window_gen_3x3_pkg;

  localparam int CW        = 10;
  localparam int IMG_W_DEF = 512;
  localparam int IMG_H_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Window tap index: row offset ro and column offset co are 0..2 for -1..+1.
  // D0 is (r-1,c-1), D4 the centre, D8 (r+1,c+1).
  function automatic logic [3:0] d_idx(input logic [1:0] ro, input logic [1:0] co);
    return (4'(ro) * 4'd3) + 4'(co);
  endfunction

  // True when an offset lands outside the image on the low or high edge.
  function automatic logic is_out(input logic [1:0] o, input logic lo_edge, input logic hi_edge);
    return ((o == 2'd0) && lo_edge) || ((o == 2'd2) && hi_edge);
  endfunction

  // Pull an out-of-image offset back onto the centre row/column.
  function automatic logic [1:0] clamp_off(input logic [1:0] o, input logic lo_edge,
                                           input logic hi_edge);
    return is_out(o, lo_edge, hi_edge) ? 2'd1 : o;
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// window_gen_3x3_line_buffer: one-row delay. Circular store of DEPTH pixels;
// each advance reads the pixel written DEPTH advances ago and overwrites it.
module window_gen_3x3_line_buffer #(
  parameter int DEPTH = 512,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_adv,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  assign o_dout = r_mem[r_ptr];

  // Pixel storage: overwrite the oldest entry on each advance
  always_ff @(posedge clk) begin
    if (i_adv) r_mem[r_ptr] <= i_din;
  end

  // Circular pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_ptr <= '0;
    else if (i_adv) r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster pixel stream -> 3x3 neighbourhood windows with border
// handling. Build option: define BORDER_REPLICATE_EN to replicate edge pixels
// instead of padding with PAD_VALUE.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int            IMG_W     = IMG_W_DEF,
  parameter int            IMG_H     = IMG_H_DEF,
  parameter int            DW        = 8,
  parameter logic [DW-1:0] PAD_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] pixel_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] D0,
  output logic [DW-1:0] D1,
  output logic [DW-1:0] D2,
  output logic [DW-1:0] D3,
  output logic [DW-1:0] D4,
  output logic [DW-1:0] D5,
  output logic [DW-1:0] D6,
  output logic [DW-1:0] D7,
  output logic [DW-1:0] D8,
  output logic [CW-1:0] Row_o,
  output logic [CW-1:0] Col_o,
  output logic [2:0]    State,
  output logic          done
);

  // A slot is one advance of the stream: an accepted pixel, or a padding
  // pixel injected during flush. Slot s completes the window centred on s-(IMG_W+1).
  localparam int            NPIX        = IMG_W * IMG_H;
  localparam int            SW          = $clog2(NPIX + IMG_W + 2);
  localparam logic [SW-1:0] SLOT_FIRST  = SW'(IMG_W + 1);
  localparam logic [SW-1:0] SLOT_LASTIN = SW'(NPIX - 1);
  localparam logic [SW-1:0] SLOT_END    = SW'(NPIX + IMG_W + 1);
  localparam logic [CW-1:0] ROW_LAST    = CW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST    = CW'(IMG_W - 1);

  state_t        r_state;
  logic [SW-1:0] r_slot;
  logic [CW-1:0] r_row, r_col;
  logic          r_done;
  logic          r_out_valid;
  logic [CW-1:0] r_row_o, r_col_o;
  logic [DW-1:0] r_win [9];

  // Column shift registers: _p1 holds the column from the previous slot,
  // _p2 the one before. Index 0 = row r-1, 1 = row r, 2 = row r+1.
  logic [DW-1:0] r_mid_p1 [3];
  logic [DW-1:0] r_old_p2 [3];

  logic          w_stall, w_in_fire, w_flush_adv, w_adv, w_emit;
  logic [DW-1:0] w_pix, w_lb1, w_lb2;
  logic          w_top, w_bot, w_lft, w_rgt;
  logic [DW-1:0] w_tap [9];
  logic [DW-1:0] w_win [9];

  assign w_stall     = r_out_valid & ~out_ready;
  assign in_ready    = ((r_state == ST_FILL) || (r_state == ST_RUN)) & ~w_stall;
  assign w_in_fire   = in_valid & in_ready;
  assign w_flush_adv = (r_state == ST_FLUSH) && (r_slot != SLOT_END) && !w_stall;
  assign w_adv       = w_in_fire | w_flush_adv;
  assign w_emit      = w_adv && (r_slot >= SLOT_FIRST);
  assign w_pix       = w_in_fire ? pixel_in : PAD_VALUE;

  assign w_top = (r_row == '0);
  assign w_bot = (r_row == ROW_LAST);
  assign w_lft = (r_col == '0);
  assign w_rgt = (r_col == COL_LAST);

  window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (w_adv),
    .i_din  (w_pix),
    .o_dout (w_lb1)
  );

  window_gen_3x3_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_lb2 (
    .clk    (clk),
    .rst    (rst),
    .i_adv  (w_adv),
    .i_din  (w_lb1),
    .o_dout (w_lb2)
  );

  // Raw taps: newest column comes straight from the line buffers and the input
  always_comb begin
    w_tap[0] = r_old_p2[0];
    w_tap[1] = r_mid_p1[0];
    w_tap[2] = w_lb2;
    w_tap[3] = r_old_p2[1];
    w_tap[4] = r_mid_p1[1];
    w_tap[5] = w_lb1;
    w_tap[6] = r_old_p2[2];
    w_tap[7] = r_mid_p1[2];
    w_tap[8] = w_pix;
  end

  // Border handling around the centre (r_row, r_col); also hides column wrap
  // and stale line-buffer contents above row 0 / below the last row.
  always_comb begin
    w_win = '{default: PAD_VALUE};
    for (logic [1:0] ro = 2'd0; ro < 2'd3; ro++) begin
      for (logic [1:0] co = 2'd0; co < 2'd3; co++) begin
`ifdef BORDER_REPLICATE_EN
        w_win[d_idx(ro, co)] =
          w_tap[d_idx(clamp_off(ro, w_top, w_bot), clamp_off(co, w_lft, w_rgt))];
`else
        if (!(is_out(ro, w_top, w_bot) || is_out(co, w_lft, w_rgt)))
          w_win[d_idx(ro, co)] = w_tap[d_idx(ro, co)];
`endif
      end
    end
  end

  // ---- stage p1/p2: column shift on every slot
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_old_p2    <= r_mid_p1;
      r_mid_p1[0] <= w_lb2;
      r_mid_p1[1] <= w_lb1;
      r_mid_p1[2] <= w_pix;
    end
  end

  // ---- output register: load on emit, hold while stalled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_win       <= '{default: '0};
      r_row_o     <= '0;
      r_col_o     <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_win       <= w_win;
      r_row_o     <= r_row;
      r_col_o     <= r_col;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Frame control FSM with slot and centre counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_adv) r_slot <= r_slot + 1'b1;
      if (w_emit) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_FILL;
            r_slot  <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        ST_FILL:  if (w_adv && (r_slot == SLOT_FIRST)) r_state <= ST_RUN;
        ST_RUN:   if (w_adv && (r_slot == SLOT_LASTIN)) r_state <= ST_FLUSH;
        ST_FLUSH: begin
          if (r_out_valid && out_ready && (r_slot == SLOT_END) &&
              (r_row_o == ROW_LAST) && (r_col_o == COL_LAST)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            r_state <= ST_FILL;
            r_slot  <= '0;
            r_row   <= '0;
            r_col   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Row_o     = r_row_o;
  assign Col_o     = r_col_o;
  assign State     = r_state;
  assign done      = r_done;
  assign D0 = r_win[0];
  assign D1 = r_win[1];
  assign D2 = r_win[2];
  assign D3 = r_win[3];
  assign D4 = r_win[4];
  assign D5 = r_win[5];
  assign D6 = r_win[6];
  assign D7 = r_win[7];
  assign D8 = r_win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed bench for window_gen_3x3 on a 4x3 ramp image
// (pixel value = raster index). Follows BORDER_REPLICATE_EN for expectations.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] pixel_in = 8'd0;
  logic       in_ready, out_valid, done;
  logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8;
  logic [9:0] Row_o, Col_o;
  logic [2:0] State;
  logic [71:0] dvec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [71:0] cap_d [128];
  logic [9:0]  cap_r [128];
  logic [9:0]  cap_c [128];
  int          cap_n  = 0;
  int          done_n = 0;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DW(8), .PAD_VALUE(8'd0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7), .D8(D8),
    .Row_o(Row_o), .Col_o(Col_o), .State(State), .done(done)
  );

  assign dvec = {D8, D7, D6, D5, D4, D3, D2, D1, D0};

  always #5 clk = ~clk;

  // Record every output transfer and every cycle with done high
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (cap_n < 128) begin
        cap_d[cap_n] = dvec;
        cap_r[cap_n] = Row_o;
        cap_c[cap_n] = Col_o;
      end
      cap_n = cap_n + 1;
    end
    if (done) done_n = done_n + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected window from image coordinates, D0 in the low byte
  function automatic logic [71:0] exp_win(input int r, input int c);
    logic [71:0] v;
    v = '0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr, cc;
        logic [7:0] p;
        rr = r + dr;
        cc = c + dc;
`ifdef BORDER_REPLICATE_EN
        if (rr < 0) rr = 0;
        if (rr > H - 1) rr = H - 1;
        if (cc < 0) cc = 0;
        if (cc > W - 1) cc = W - 1;
        p = 8'(rr * W + cc);
`else
        p = (rr < 0 || rr >= H || cc < 0 || cc >= W) ? 8'd0 : 8'(rr * W + cc);
`endif
        v[((dr + 1) * 3 + (dc + 1)) * 8 +: 8] = p;
      end
    end
    return v;
  endfunction

  // mode: 0 plain, 1 backpressure at (1,2), 2 input bubbles, 3 start pulse in RUN
  task automatic run_frame(input int mode, input bit skip_start, input bit restart_at_end);
    int pix, base, dbase, bp;
    bit chk_first, seen, chk_ign;
    pix = 0; bp = 0; chk_first = 0; seen = 0; chk_ign = 0;
    base  = cap_n;
    dbase = done_n;
    if (!skip_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk($sformatf("m%0d_fill_state", mode), 72'(State), 72'(1));
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (restart_at_end && State === 3'd4) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        break;
      end
      if (done_n != dbase && State === 3'd0) break;
      in_valid  = (pix < W * H) && (mode != 2 || (cyc % 2) == 0);
      pixel_in  = 8'(pix);
      out_ready = 1'b1;
      if (mode == 1 && out_valid && Row_o == 10'd1 && Col_o == 10'd2 && bp < 3) begin
        out_ready = 1'b0;
        bp++;
      end
      start = 1'b0;
      if (mode == 3 && pix == 8 && !seen) begin
        start = 1'b1; seen = 1; chk_ign = 1;
      end
      @(negedge clk);
      if (chk_first) begin
        chk("first_valid", 72'(out_valid), 72'(1));
        chk("first_pos", 72'({Row_o, Col_o}), 72'(0));
        chk_first = 0;
      end
      if (!out_ready) begin
        chk("hold_row", 72'(Row_o), 72'(1));
        chk("hold_col", 72'(Col_o), 72'(2));
        chk("hold_win", dvec, exp_win(1, 2));
        chk("hold_in_ready", 72'(in_ready), 72'(0));
      end
      if (in_valid && in_ready) begin
        if (mode == 0 && pix == W + 1) begin
          chk("valid_before_idx5", 72'(out_valid), 72'(0));
          chk_first = 1;
        end
        pix++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (chk_ign) begin
        chk("start_ignored", 72'(State), 72'(2));
        chk_ign = 0;
      end
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk($sformatf("m%0d_done_seen", mode), 72'(done_n != dbase), 72'(1));
    if (restart_at_end) chk("restart_fill", 72'(State), 72'(1));
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("m%0d_done_pulses", mode), 72'(done_n - dbase), 72'(1));
    chk($sformatf("m%0d_win_count", mode), 72'(cap_n - base), 72'(W * H));
    if (mode == 1) chk("bp_cycles", 72'(bp), 72'(3));
    for (int i = 0; i < W * H; i++) begin
      if (base + i < 128) begin
        chk($sformatf("m%0d_pos%0d", mode, i), 72'({cap_r[base + i], cap_c[base + i]}),
            72'({10'(i / W), 10'(i % W)}));
        chk($sformatf("m%0d_win%0d", mode, i), cap_d[base + i], exp_win(i / W, i % W));
      end
    end
  endtask

  initial begin
    int b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_state", 72'(State), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    @(posedge clk); #1;

    // Plain ramp frame, plus the hand-computed windows
    b = cap_n;
    run_frame(0, 0, 0);
`ifdef BORDER_REPLICATE_EN
    chk("lit_0_0", cap_d[b + 0],  72'h050404010000010000);
    chk("lit_1_1", cap_d[b + 5],  72'h0a0908060504020100);
    chk("lit_2_3", cap_d[b + 11], 72'h0b0b0a0b0b0a070706);
`else
    chk("lit_0_0", cap_d[b + 0],  72'h050400010000000000);
    chk("lit_1_1", cap_d[b + 5],  72'h0a0908060504020100);
    chk("lit_2_3", cap_d[b + 11], 72'h000000000b0a000706);
`endif
    chk("idle_after_frame", 72'(State), 72'(0));

    // Reset in the middle of a frame
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pixel_in = 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pre_rst_run", 72'(State), 72'(2));
    chk("pre_rst_valid", 72'(out_valid), 72'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_state", 72'(State), 72'(0));
    chk("mid_rst_out_valid", 72'(out_valid), 72'(0));
    chk("mid_rst_in_ready", 72'(in_ready), 72'(0));
    chk("mid_rst_done", 72'(done), 72'(0));
    chk("mid_rst_D", dvec, 72'(0));
    chk("mid_rst_pos", 72'({Row_o, Col_o}), 72'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(1, 0, 0);   // backpressure at (1,2)
    run_frame(2, 0, 0);   // in_valid bubbles
    run_frame(3, 0, 1);   // start ignored in RUN, restart from DONE
    run_frame(0, 1, 0);   // second frame after restart

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
